// File: rtl/puzzle_hex_pkg.sv
// Shared widths, constants and shadow payload for the hex-display dimmer.
package puzzle_hex_pkg;

  localparam int unsigned SEG_W    = 7;
  localparam int unsigned BRIGHT_W = 4;

  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL   = 4'd15;
  localparam logic [SEG_W-1:0]    SEG_ALL_OFF_N = 7'h7F;

  // Inputs captured once per PWM period so CPU writes never land mid-period
  typedef struct packed {
    logic [SEG_W-1:0]    seg;
    logic [BRIGHT_W-1:0] bright;
    logic                blink;
  } shadow_t;

endpackage

// File: rtl/puzzle_hex_tick_gen.sv
// Free-running prescaler: single-cycle tick once every TICK_DIV clocks.
module puzzle_hex_tick_gen #(
  parameter int unsigned TICK_DIV = 195
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;

  always_comb begin
    tick       = (tick_cnt_q == CNT_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/puzzle_hex_dimmer.sv
// PWM brightness and blink stage between a hex PIO and active-low segment pins.
module puzzle_hex_dimmer
  import puzzle_hex_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 195,
  parameter int unsigned BLINK_PERIODS = 8000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [SEG_W-1:0]    seg_in,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic                blink_en,
  output logic [SEG_W-1:0]    hex_n,
  output logic                frame
);

  localparam int unsigned BLINK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);

  logic                tick;
  logic                period_start;
  logic                on;
  logic [BRIGHT_W-1:0] pwm_cnt_q,     pwm_cnt_d;
  logic [BLINK_W-1:0]  blink_cnt_q,   blink_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  shadow_t             shadow_q,      shadow_d;
  logic [SEG_W-1:0]    hex_n_q,       hex_n_d;
  logic                frame_q,       frame_d;

  puzzle_hex_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  always_comb begin
    pwm_cnt_d     = pwm_cnt_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    shadow_d      = shadow_q;

    period_start = tick && (pwm_cnt_q == '1);

    if (tick) begin
      pwm_cnt_d = pwm_cnt_q + BRIGHT_W'(1);
    end

    // Blink state tracks the pre-load shadow; a falling blink_en forces visible phase
    if (!shadow_q.blink) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (period_start) begin
      if (!blink_en) begin
        blink_cnt_d   = '0;
        blink_phase_d = 1'b1;
      end else if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLINK_W'(1);
      end
    end

    if (period_start) begin
      shadow_d.seg    = seg_in;
      shadow_d.bright = brightness;
      shadow_d.blink  = blink_en;
    end

    on      = (shadow_q.bright == BRIGHT_FULL) || (pwm_cnt_q < shadow_q.bright);
    hex_n_d = ~(shadow_q.seg & {SEG_W{on & blink_phase_q}});
    frame_d = period_start;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt_q     <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      shadow_q      <= '0;
      hex_n_q       <= SEG_ALL_OFF_N;
      frame_q       <= 1'b0;
    end else begin
      pwm_cnt_q     <= pwm_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      shadow_q      <= shadow_d;
      hex_n_q       <= hex_n_d;
      frame_q       <= frame_d;
    end
  end

  assign hex_n = hex_n_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_puzzle_hex_dimmer.sv
// Scoreboard bench for puzzle_hex_dimmer (TICK_DIV=2, BLINK_PERIODS=2) plus a TICK_DIV=5 tick generator.
module tb_puzzle_hex_dimmer;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] brightness;
  logic       blink_en;
  logic [6:0] hex_n;
  logic       frame;
  logic       tick5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0] hex;
    logic       frame;
    logic       tick5;
  } exp_t;

  exp_t sb[$];

  puzzle_hex_dimmer #(
    .TICK_DIV      (2),
    .BLINK_PERIODS (2)
  ) dut (
    .clk        (clk),
    .reset_n    (rst_n),
    .seg_in     (seg_in),
    .brightness (brightness),
    .blink_en   (blink_en),
    .hex_n      (hex_n),
    .frame      (frame)
  );

  puzzle_hex_tick_gen #(
    .TICK_DIV (5)
  ) u_tick5 (
    .clk     (clk),
    .reset_n (rst_n),
    .tick    (tick5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: e = clock edges since reset release; pwm_cnt = (e/2)%16,
  // frames every 32 edges; blink visibility from count of blinking periods.
  initial begin
    int         e;
    int         pwm;
    int         bper;
    logic [6:0] m_seg;
    logic [3:0] m_bright;
    logic       m_blink;
    logic       lit;
    exp_t       x;
    e = 0; bper = 0; m_seg = '0; m_bright = '0; m_blink = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        e = 0; bper = 0; m_seg = '0; m_bright = '0; m_blink = 1'b0;
        x.hex = 7'h7F; x.frame = 1'b0; x.tick5 = 1'b0;
      end else begin
        pwm     = (e / 2) % 16;
        lit     = ((m_bright == 4'd15) || (pwm < int'(m_bright))) &&
                  (!m_blink || (((bper / 2) % 2) == 0));
        x.hex   = lit ? ~m_seg : 7'h7F;
        x.frame = ((e + 1) % 32) == 0;
        x.tick5 = ((e + 1) % 5) == 4;
        if (x.frame) begin
          if (m_blink && blink_en) bper = bper + 1;
          else bper = 0;
          m_seg = seg_in; m_bright = brightness; m_blink = blink_en;
        end
        e = e + 1;
      end
      sb.push_back(x);
    end
  end

  // Monitor: compare DUT outputs with the queued expectation every cycle
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks = checks + 3;
        if (hex_n !== x.hex) begin
          errors++;
          $display("FAIL hex_n at %0t: got %h expected %h", $time, hex_n, x.hex);
        end
        if (frame !== x.frame) begin
          errors++;
          $display("FAIL frame at %0t: got %b expected %b", $time, frame, x.frame);
        end
        if (tick5 !== x.tick5) begin
          errors++;
          $display("FAIL tick5 at %0t: got %b expected %b", $time, tick5, x.tick5);
        end
      end
    end
  end

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (frame) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_frame: got timeout expected frame within 100 clocks");
    end
  endtask

  task automatic count_period(input string name, input logic [6:0] val, input int want);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (hex_n == val) n++;
    end
    check_val(name, n, want);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; seg_in = '0; brightness = '0; blink_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Full brightness digit "0"
    seg_in = 7'h3F; brightness = 4'd15;
    wait_frame();
    count_period("full_bright_lit", 7'h40, 32);

    // Duty 4/16 and blank
    seg_in = 7'h06; brightness = 4'd4;
    wait_frame();
    count_period("duty4_lit", 7'h79, 8);
    brightness = 4'd0;
    wait_frame();
    count_period("bright0_dark", 7'h7F, 32);

    // Mid-period write is deferred to the next frame
    seg_in = 7'h06; brightness = 4'd15;
    wait_frame();
    repeat (10) @(negedge clk);
    seg_in = 7'h5B;
    repeat (15) @(negedge clk);
    check_val("glitch_hold_old", int'(hex_n), 'h79);
    wait_frame();
    @(negedge clk);
    check_val("glitch_new_pattern", int'(hex_n), 'h24);

    // Blink: two lit periods, two dark; clearing mid-dark relights at next frame
    seg_in = 7'h7F; blink_en = 1'b1;
    wait_frame();
    wait_frame();
    wait_frame();
    repeat (16) @(negedge clk);
    check_val("blink_dark_half", int'(hex_n), 'h7F);
    blink_en = 1'b0;
    wait_frame();
    @(negedge clk);
    check_val("blink_clear_relit", int'(hex_n), 'h00);

    // Asynchronous reset mid-period
    repeat (7) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_val("reset_async_hex", int'(hex_n), 'h7F);
    check_val("reset_async_frame", int'(frame), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (frame) break;
    end
    check_val("first_frame_latency", n, 32);
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
